// File: rtl/cs_mix_pkg.sv
// Shared types and helper functions for the CS-Cipher mixing layer.
package cs_mix_pkg;
    import p_table_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    localparam logic [7:0] PHI_MASK = 8'h55;

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] phi(input logic [7:0] v);
        return (rotl1(v) & PHI_MASK) ^ v;
    endfunction

    // Reference form of M, result packed as {yl, yr}.
    function automatic logic [15:0] m_lookup(input logic [7:0] xl, input logic [7:0] xr);
        return {p_lookup(phi(xl) ^ xr), p_lookup(rotl1(xl) ^ xr)};
    endfunction

endpackage

// File: rtl/p_table_pkg.sv
// CS-Cipher nonlinear byte permutation P: a three-round nibble Feistel
// network built on the small functions f and g.
package p_table_pkg;

    // Nibble tables, entry 0 in the least significant nibble.
    localparam logic [63:0] F_TAB = 64'hFEDE_BADE_7757_BBDF;
    localparam logic [63:0] G_TAB = 64'h97CF_354D_81EB_206A;

    function automatic logic [3:0] p_f(input logic [3:0] x);
        return F_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] p_g(input logic [3:0] x);
        return G_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] p_lookup(input logic [7:0] x);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] e;
        c = x[7:4] ^ p_f(x[3:0]);
        d = x[3:0] ^ p_g(c);
        e = c ^ p_f(d);
        return {e, d};
    endfunction

endpackage

// File: rtl/cs_m_func.sv
// Combinational 16-bit mixing function M over one byte pair.
module cs_m_func
    import cs_mix_pkg::*;
(
    input  logic [7:0] xl,
    input  logic [7:0] xr,
    output logic [7:0] yl,
    output logic [7:0] yr
);

    logic [7:0] p_in_l;
    logic [7:0] p_in_r;

    assign p_in_l = phi(xl) ^ xr;
    assign p_in_r = rotl1(xl) ^ xr;

    p_module u_p_l (
        .x (p_in_l),
        .y (yl)
    );

    p_module u_p_r (
        .x (p_in_r),
        .y (yr)
    );

endmodule

// File: rtl/p_module.sv
// Combinational CS-Cipher byte permutation P.
module p_module
    import p_table_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = p_lookup(x);

endmodule

// File: rtl/cs_mix_layer.sv
// Sequential mixing layer: XOR key into the state, then apply M to one
// byte pair per cycle using a single time-shared M instance.
module cs_mix_layer
    import cs_mix_pkg::*;
#(
    parameter int NPAIRS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*NPAIRS-1:0]  in_data,
    input  logic [16*NPAIRS-1:0]  in_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*NPAIRS-1:0]  out_data,
    output logic                  busy
);

    localparam int W  = 16 * NPAIRS;
    localparam int CW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NPAIRS - 1);

    mix_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  w_q, w_d;

    logic [15:0]   pair_w [NPAIRS];
    logic [15:0]   pair_sel;
    logic [7:0]    m_yl;
    logic [7:0]    m_yr;

    genvar gi;
    generate
        for (gi = 0; gi < NPAIRS; gi++) begin : g_pair
            assign pair_w[gi] = w_q[16*gi +: 16];
        end
    endgenerate

    assign pair_sel = pair_w[cnt_q];

    cs_m_func u_m (
        .xl (pair_sel[15:8]),
        .xr (pair_sel[7:0]),
        .yl (m_yl),
        .yr (m_yr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_d     = in_data ^ in_key;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NPAIRS; i++) begin
                    if (cnt_q == i[CW-1:0]) begin
                        w_d[16*i +: 16] = {m_yl, m_yr};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result held until the consumer takes it; no new accept on this edge.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = w_q;

endmodule

// File: tb/tb_cs_mix_layer.sv
// Self-checking bench for cs_mix_layer: directed table, random blocks with
// stalls, mid-run reset and back-to-back throughput.
module tb_cs_mix_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cs_mix_layer #(.NPAIRS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Independent model of P and M.
    int f_tab [16] = '{15, 13, 11, 11, 7, 5, 7, 7, 14, 13, 10, 11, 14, 13, 14, 15};
    int g_tab [16] = '{10, 6, 0, 2, 11, 14, 1, 8, 13, 4, 5, 3, 15, 12, 7, 9};

    function automatic int tb_p(input int x);
        int l, r, c, d, e;
        l = (x >> 4) & 15;
        r = x & 15;
        c = l ^ f_tab[r];
        d = r ^ g_tab[c];
        e = c ^ f_tab[d];
        return e * 16 + d;
    endfunction

    function automatic int tb_rot(input int v);
        return ((v << 1) | (v >> 7)) & 255;
    endfunction

    function automatic logic [63:0] tb_mix(input logic [63:0] w);
        logic [63:0] r;
        int xl, xr, yl, yr;
        r = w;
        for (int i = 0; i < 4; i++) begin
            xl = int'(w[16*i+8 +: 8]);
            xr = int'(w[16*i +: 8]);
            yl = tb_p(((tb_rot(xl) & 85) ^ xl) ^ xr);
            yr = tb_p(tb_rot(xl) ^ xr);
            r[16*i +: 16] = {yl[7:0], yr[7:0]};
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Runs one block from IDLE; time is just after a rising edge on entry and exit.
    task automatic run_block(input logic [63:0] d, input logic [63:0] k,
                             input int stall, input bit garbage, input string nm);
        logic [63:0] exp;
        int cyc;
        exp = tb_mix(d ^ k);
        check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        @(posedge clk); #1;
        if (garbage) begin
            in_data = {$urandom, $urandom};
            in_key  = {$urandom, $urandom};
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check({nm, "_busy"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_latency"}, 64'(cyc), 64'd4);
        check({nm, "_data"}, out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
            check({nm, "_stall_data"}, out_data, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_post_valid"}, 64'(out_valid), 64'd0);
        check({nm, "_post_ready"}, 64'(in_ready), 64'd1);
        $display("block %s data=%h key=%h out=%h", nm, d, k, exp);
    endtask

    typedef struct {
        logic [63:0] d;
        logic [63:0] k;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  p0;
        logic [15:0] zp;
        logic [63:0] bd [4];
        logic [63:0] bk [4];
        int          acc_cyc [$];
        int          nout;
        int          idx;
        int          seen;
        bit          acc;
        int          tmp;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;

        tmp = tb_p(0); p0 = tmp[7:0];
        zp  = {p0, p0};
        vecs[0] = '{64'h0, 64'h0, {4{zp}}, "zero"};
        vecs[1] = '{64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, {4{zp}}, "self_cancel"};
        tmp = tb_p(8'h81);
        vecs[2].exp[63:56] = tmp[7:0];
        tmp = tb_p(8'h01);
        vecs[2].exp[55:48] = tmp[7:0];
        vecs[2].exp[47:0]  = {3{zp}};
        vecs[2].d  = 64'h8000_0000_0000_0000;
        vecs[2].k  = 64'h0;
        vecs[2].nm = "msb_pair3";

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_data", out_data, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
            check("m_lookup", 64'(cs_mix_pkg::m_lookup(a, b)), 64'(tb_mix({48'h0, a, b}) & 64'hFFFF));
        end

        for (int i = 0; i < 3; i++) begin
            check({vecs[i].nm, "_table_model"}, tb_mix(vecs[i].d ^ vecs[i].k), vecs[i].exp);
            run_block(vecs[i].d, vecs[i].k, 1, 1'b0, vecs[i].nm);
        end

        for (int i = 0; i < 1000; i++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom},
                      int'($urandom_range(0, 3)), bit'($urandom & 1), $sformatf("rand%0d", i));
        end

        // Reset while the block is in RUN with cnt=1.
        in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; in_key = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("rst_no_result", 64'(seen), 64'd0);
        $display("midrun reset discarded block, outputs seen=%0d", seen);
        run_block(64'hCAFEF00D_12345678, 64'h0F0F0F0F_F0F0F0F0, 0, 1'b0, "after_rst");

        // Back-to-back with out_ready tied high.
        for (int i = 0; i < 4; i++) begin
            bd[i] = {$urandom, $urandom};
            bk[i] = {$urandom, $urandom};
        end
        idx = 0; nout = 0;
        in_valid = 1'b1; in_data = bd[0]; in_key = bk[0]; out_ready = 1'b1;
        for (int c = 1; c <= 40 && nout < 4; c++) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(c);
                idx++;
                if (idx < 4) begin
                    in_data = bd[idx]; in_key = bk[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check($sformatf("b2b_data%0d", nout), out_data, tb_mix(bd[nout] ^ bk[nout]));
                $display("b2b block %0d out=%h cycle=%0d", nout, out_data, c);
                nout++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_outputs", 64'(nout), 64'd4);
        check("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check($sformatf("b2b_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
